// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the shared ALU, the response consumer and the arbiter.
// master = surrounding system, slave = arbiter.
interface alu_arbiter_if #(parameter int n = 64);
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [n-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]   req0_opt, req1_opt;
  logic [n-1:0] alu_in1, alu_in2;
  logic [3:0]   alu_opt;
  logic [n-1:0] alu_out;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [n-1:0] rsp_data;

  modport master (
    output req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_opt, req1_opt, alu_out, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_in1, alu_in2, alu_opt,
           rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2,
           req0_opt, req1_opt, alu_out, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_in1, alu_in2, alu_opt,
           rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it.
module alu_arbiter #(
  parameter int n = 64
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_last_grant;
  logic         r_id;
  logic [n-1:0] r_in1, r_in2;
  logic [3:0]   r_opt;
  logic         r_rsp_valid, r_rsp_id, r_rsp_zero, r_rsp_err;
  logic [n-1:0] r_rsp_data;

  logic w_idle, w_grant0, w_grant1, w_legal;

  // Contention goes to whoever did not win last time.
  assign w_idle   = (r_state == IDLE) && !reset;
  assign w_grant0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_grant1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  always_comb begin
    w_legal = 1'b0;
    case (r_opt)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_in1        <= '0;
      r_in2        <= '0;
      r_opt        <= 4'b0000;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_in1        <= bus.req0_in1;
            r_in2        <= bus.req0_in2;
            r_opt        <= bus.req0_opt;
            r_id         <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= EXEC;
          end else if (w_grant1) begin
            r_in1        <= bus.req1_in1;
            r_in2        <= bus.req1_in2;
            r_opt        <= bus.req1_opt;
            r_id         <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          // An illegal opcode yields a flagged zero result regardless of the ALU.
          r_rsp_data  <= w_legal ? bus.alu_out : '0;
          r_rsp_zero  <= w_legal ? bus.alu_zero : 1'b1;
          r_rsp_err   <= !w_legal;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.alu_in1    = r_in1;
  assign bus.alu_in2    = r_in2;
  assign bus.alu_opt    = r_opt;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU, cycle model of the arbiter and a response scoreboard.
module tb_alu_arbiter;
  localparam int N = 64;

  logic clk;
  logic reset;
  alu_arbiter_if #(.n(N)) bus ();

  alu_arbiter #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   opt;
    logic [N-1:0] data;
    logic         zero;
    logic         err;
  } entry_t;

  typedef struct {
    logic         id;
    logic [N-1:0] data;
    logic         zero;
  } rsp_t;

  int     checks = 0;
  int     failures = 0;
  entry_t sb[$];
  rsp_t   rsp_log[$];
  int     m_st;
  logic   m_last;
  logic   acc_flag;
  logic   acc_id;

  function automatic logic [N-1:0] alu_fn(input logic [3:0] opt, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    case (opt)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
      4'b1100: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] opt);
    return (opt == 4'h0) || (opt == 4'h1) || (opt == 4'h2) ||
           (opt == 4'h6) || (opt == 4'h7) || (opt == 4'hC);
  endfunction

  function automatic entry_t mk_entry(input logic id, input logic [N-1:0] a,
                                      input logic [N-1:0] b, input logic [3:0] opt);
    entry_t e;
    e.id = id; e.a = a; e.b = b; e.opt = opt;
    if (is_legal(opt)) begin
      e.data = alu_fn(opt, a, b);
      e.zero = (e.data == '0);
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.zero = 1'b1;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Environment ALU; illegal opcodes produce a nonzero XOR so that ignoring it is visible.
  always_comb begin
    bus.alu_out  = alu_fn(bus.alu_opt, bus.alu_in1, bus.alu_in2);
    bus.alu_zero = (bus.alu_out == '0);
  end

  task automatic tick();
    logic e0, e1, rr, rid;
    logic [N-1:0] rdata;
    logic rzero;
    #1;
    e0 = (m_st == 0) && !reset && bus.req0_valid && (!bus.req1_valid || m_last);
    e1 = (m_st == 0) && !reset && bus.req1_valid && (!bus.req0_valid || !m_last);
    checks++;
    if (bus.req0_ready !== e0) begin
      failures++;
      $display("FAIL req0_ready t=%0t got=%b want=%b", $time, bus.req0_ready, e0);
    end
    checks++;
    if (bus.req1_ready !== e1) begin
      failures++;
      $display("FAIL req1_ready t=%0t got=%b want=%b", $time, bus.req1_ready, e1);
    end
    checks++;
    if (bus.rsp_valid !== (m_st == 2)) begin
      failures++;
      $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, bus.rsp_valid, (m_st == 2));
    end
    if (m_st == 1 && sb.size() > 0) begin
      checks++;
      if (bus.alu_in1 !== sb[0].a || bus.alu_in2 !== sb[0].b || bus.alu_opt !== sb[0].opt) begin
        failures++;
        $display("FAIL alu_operands t=%0t got=%h,%h,%h want=%h,%h,%h", $time, bus.alu_in1,
                 bus.alu_in2, bus.alu_opt, sb[0].a, sb[0].b, sb[0].opt);
      end
    end
    if (m_st == 2 && sb.size() > 0) begin
      checks++;
      if (bus.rsp_data !== sb[0].data || bus.rsp_zero !== sb[0].zero ||
          bus.rsp_err !== sb[0].err || bus.rsp_id !== sb[0].id) begin
        failures++;
        $display("FAIL rsp_fields t=%0t got d=%h z=%b e=%b id=%b want d=%h z=%b e=%b id=%b",
                 $time, bus.rsp_data, bus.rsp_zero, bus.rsp_err, bus.rsp_id,
                 sb[0].data, sb[0].zero, sb[0].err, sb[0].id);
      end
    end
    rr = bus.rsp_ready;
    rid = bus.rsp_id;
    rdata = bus.rsp_data;
    rzero = bus.rsp_zero;
    acc_flag = 1'b0;
    @(posedge clk);
    if (reset) begin
      m_st = 0;
      m_last = 1'b1;
      sb.delete();
    end else begin
      case (m_st)
        0: begin
          if (e0) begin
            sb.push_back(mk_entry(1'b0, bus.req0_in1, bus.req0_in2, bus.req0_opt));
            m_last = 1'b0; m_st = 1; acc_flag = 1'b1; acc_id = 1'b0;
          end else if (e1) begin
            sb.push_back(mk_entry(1'b1, bus.req1_in1, bus.req1_in2, bus.req1_opt));
            m_last = 1'b1; m_st = 1; acc_flag = 1'b1; acc_id = 1'b1;
          end
        end
        1: m_st = 2;
        default: begin
          if (rr) begin
            rsp_log.push_back('{id: rid, data: rdata, zero: rzero});
            if (sb.size() > 0) void'(sb.pop_front());
            m_st = 0;
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] opt);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_in1 = a; bus.req0_in2 = b; bus.req0_opt = opt;
    end else begin
      bus.req1_valid = v; bus.req1_in1 = a; bus.req1_in2 = b; bus.req1_opt = opt;
    end
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic apply_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_readies got=%b%b want=00", bus.req0_ready, bus.req1_ready);
    end
    apply_reset();
    #1;
    checks++;
    if (bus.alu_in1 !== '0 || bus.alu_in2 !== '0 || bus.alu_opt !== 4'b0000 ||
        bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got in1=%h in2=%h opt=%h v=%b d=%h z=%b e=%b id=%b want all 0",
               bus.alu_in1, bus.alu_in2, bus.alu_opt, bus.rsp_valid, bus.rsp_data,
               bus.rsp_zero, bus.rsp_err, bus.rsp_id);
    end
  endtask

  task automatic test_single_op();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, N'(5), N'(3), 4'b0010);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== N'(8) || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_op got v=%b d=%0d z=%b id=%b e=%b want v=1 d=8 z=0 id=0 e=0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id, bus.rsp_err);
    end
    drain();
  endtask

  task automatic test_contention();
    apply_reset();
    rsp_log.delete();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, N'(5), N'(5), 4'b0110);
    set_req(1, 1'b1, N'('hF0), N'('h0F), 4'b0001);
    for (int i = 0; i < 13; i++) tick();
    drain();
    checks++;
    if (rsp_log.size() < 4) begin
      failures++;
      $display("FAIL contention_count got=%0d want>=4", rsp_log.size());
    end
    for (int i = 0; i < rsp_log.size(); i++) begin
      checks++;
      if (rsp_log[i].id !== 1'(i % 2)) begin
        failures++;
        $display("FAIL contention_grant idx=%0d got=%b want=%0d", i, rsp_log[i].id, i % 2);
      end
      checks++;
      if ((i % 2 == 0 && (rsp_log[i].data !== '0 || rsp_log[i].zero !== 1'b1)) ||
          (i % 2 == 1 && rsp_log[i].data !== N'('hFF))) begin
        failures++;
        $display("FAIL contention_data idx=%0d got d=%h z=%b want %s", i, rsp_log[i].data,
                 rsp_log[i].zero, (i % 2 == 0) ? "d=0 z=1" : "d=ff");
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] snap;
    int k;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, N'(100), N'(58), 4'b0110);
    tick();
    set_req(1, 1'b1, N'(1), N'(1), 4'b0010);
    k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 6) begin
      tick();
      k++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_rsp_valid got=%b want=1", bus.rsp_valid);
    end
    snap = bus.rsp_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.rsp_data !== snap || bus.rsp_valid !== 1'b1 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got d=%h v=%b r=%b%b want d=%h v=1 r=00", i,
                 bus.rsp_data, bus.rsp_valid, bus.req0_ready, bus.req1_ready, snap);
      end
    end
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b r0=%b want v=0 r0=1", bus.rsp_valid, bus.req0_ready);
    end
    drain();
  endtask

  task automatic test_illegal();
    bus.rsp_ready = 1'b1;
    set_req(1, 1'b1, N'('hAA), N'('h55), 4'b1111);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== '0 ||
        bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op got v=%b e=%b d=%h z=%b id=%b want v=1 e=1 d=0 z=1 id=1",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, N'(1), N'(2), 4'b0010);
    tick();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.alu_opt !== 4'b0000 || bus.alu_in1 !== '0) begin
      failures++;
      $display("FAIL reset_mid_opt got opt=%h in1=%h want opt=0 in1=0", bus.alu_opt, bus.alu_in1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_rsp cyc=%0d got=%b want=0", i, bus.rsp_valid);
      end
    end
    set_req(0, 1'b1, N'(7), N'(7), 4'b0000);
    set_req(1, 1'b1, N'(9), N'(9), 4'b0000);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_first_grant got=%b%b want=10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_starvation();
    int idle_seen;
    logic got;
    apply_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, N'(3), N'(4), 4'b0000);
    set_req(1, 1'b1, N'(6), N'(2), 4'b0110);
    idle_seen = 0;
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      bus.req0_valid = (i % 2 == 0);
      if (m_st == 0) idle_seen++;
      tick();
      if (acc_flag && acc_id == 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || idle_seen > 2) begin
      failures++;
      $display("FAIL starvation got accepted=%b idle_cycles=%0d want accepted=1 idle_cycles<=2",
               got, idle_seen);
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    m_st = 0;
    m_last = 1'b1;
    acc_flag = 1'b0;
    acc_id = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, '0, '0, 4'b0000);
    set_req(1, 1'b0, '0, '0, 4'b0000);
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
